imm_gen_pipe: RTL and testbench

//  Registered, parametrised immediate generator for the ID stage. Decodes the format of one
//  32-bit instruction per cycle and emits the XLEN sign-extended immediate, the format code,
//  an illegal flag and the PC-relative target (pc + imm). A valid/ready handshake with a
//  2-entry skid buffer lets the decode stage stall and flush without losing instructions.

---
 rtl/imm_gen_pkg.sv | 108 ++++++++++
 rtl/imm_skid_buf.sv | 78 +++++++
 rtl/imm_gen_pipe.sv | 60 ++++++
 tb/tb_imm_gen_pipe.sv | 323 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/imm_gen_pkg.sv
// Shared types, opcode constants and the immediate decoder for imm_gen_pipe.
// Optional build macro IMM_GEN_CSR_EN: decode CSR-immediate forms as fmt Z.
package imm_gen_pkg;

  typedef enum logic [2:0] {
    FmtNone = 3'd0,
    FmtR    = 3'd1,
    FmtI    = 3'd2,
    FmtS    = 3'd3,
    FmtB    = 3'd4,
    FmtU    = 3'd5,
    FmtJ    = 3'd6,
    FmtZ    = 3'd7
  } fmt_e;

  localparam logic [6:0] OPC_LOAD      = 7'b0000011;
  localparam logic [6:0] OPC_OP_IMM    = 7'b0010011;
  localparam logic [6:0] OPC_JALR      = 7'b1100111;
  localparam logic [6:0] OPC_STORE     = 7'b0100011;
  localparam logic [6:0] OPC_BRANCH    = 7'b1100011;
  localparam logic [6:0] OPC_LUI       = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC     = 7'b0010111;
  localparam logic [6:0] OPC_JAL       = 7'b1101111;
  localparam logic [6:0] OPC_OP        = 7'b0110011;
  localparam logic [6:0] OPC_OP_IMM_32 = 7'b0011011;
  localparam logic [6:0] OPC_OP_32     = 7'b0111011;
  localparam logic [6:0] OPC_SYSTEM    = 7'b1110011;

  typedef struct packed {
    logic [63:0] imm;
    fmt_e        fmt;
    logic        illegal;
  } dec_t;

  // Immediate is always built 64 bits wide; narrower datapaths keep the low bits.
  function automatic dec_t decode_imm(input logic [31:0] instr, input logic rv64);
    dec_t d;
    logic [63:0] imm_i;
    imm_i     = {{52{instr[31]}}, instr[31:20]};
    d.imm     = '0;
    d.fmt     = FmtNone;
    d.illegal = 1'b0;
    if (instr[1:0] != 2'b11) begin
      d.illegal = 1'b1;
    end else begin
      case (instr[6:0])
        OPC_LOAD, OPC_OP_IMM, OPC_JALR: begin
          d.fmt = FmtI;
          d.imm = imm_i;
        end
        OPC_STORE: begin
          d.fmt = FmtS;
          d.imm = {{52{instr[31]}}, instr[31:25], instr[11:7]};
        end
        OPC_BRANCH: begin
          d.fmt = FmtB;
          d.imm = {{51{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
        end
        OPC_LUI, OPC_AUIPC: begin
          d.fmt = FmtU;
          d.imm = {{32{instr[31]}}, instr[31:12], 12'b0};
        end
        OPC_JAL: begin
          d.fmt = FmtJ;
          d.imm = {{43{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};
        end
        OPC_OP: begin
          d.fmt = FmtR;
        end
        OPC_OP_IMM_32: begin
          if (rv64) begin
            d.fmt = FmtI;
            d.imm = imm_i;
          end else begin
            d.illegal = 1'b1;
          end
        end
        OPC_OP_32: begin
          if (rv64) begin
            d.fmt = FmtR;
          end else begin
            d.illegal = 1'b1;
          end
        end
        OPC_SYSTEM: begin
`ifdef IMM_GEN_CSR_EN
          // funct3[2] selects the uimm CSR forms (csrrwi/csrrsi/csrrci)
          if (instr[14]) begin
            d.fmt = FmtZ;
            d.imm = {59'b0, instr[19:15]};
          end else begin
            d.fmt = FmtI;
            d.imm = imm_i;
          end
`else
          d.fmt = FmtI;
          d.imm = imm_i;
`endif
        end
        default: begin
          d.illegal = 1'b1;
        end
      endcase
    end
    return d;
  endfunction

endpackage

// File: rtl/imm_skid_buf.sv
// Generic valid/ready pipeline stage: one output register plus one skid entry, with flush.
module imm_skid_buf #(
  parameter int unsigned W = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         flush,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] in_data,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] out_data
);

  logic         out_valid_q, out_valid_d;
  logic [W-1:0] out_data_q, out_data_d;
  logic         skid_valid_q, skid_valid_d;
  logic [W-1:0] skid_data_q, skid_data_d;
  logic         rdy_q, rdy_d;
  logic         acc, drain;

  always_comb begin
    acc          = in_valid && rdy_q;
    drain        = out_valid_q && out_ready;
    out_valid_d  = out_valid_q;
    out_data_d   = out_data_q;
    skid_valid_d = skid_valid_q;
    skid_data_d  = skid_data_q;
    if (flush) begin
      out_valid_d  = 1'b0;
      skid_valid_d = 1'b0;
    end else if (!out_valid_q || drain) begin
      if (skid_valid_q) begin
        // Older skid beat goes first to keep FIFO order
        out_valid_d  = 1'b1;
        out_data_d   = skid_data_q;
        skid_valid_d = acc;
        if (acc) begin
          skid_data_d = in_data;
        end
      end else begin
        out_valid_d = acc;
        if (acc) begin
          out_data_d = in_data;
        end
      end
    end else if (acc) begin
      skid_valid_d = 1'b1;
      skid_data_d  = in_data;
    end
    rdy_d = !skid_valid_d;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      out_valid_q  <= 1'b0;
      out_data_q   <= '0;
      skid_valid_q <= 1'b0;
      skid_data_q  <= '0;
      rdy_q        <= 1'b0;
    end else begin
      out_valid_q  <= out_valid_d;
      out_data_q   <= out_data_d;
      skid_valid_q <= skid_valid_d;
      skid_data_q  <= skid_data_d;
      rdy_q        <= rdy_d;
    end
  end

  assign in_ready  = rdy_q;
  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;

  skid_behind_output: assert property (@(posedge clk) disable iff (!rst_n)
    skid_valid_q |-> out_valid_q);

endmodule

// File: rtl/imm_gen_pipe.sv
// Registered immediate generator: decodes format/immediate/target and buffers through a skid.
// Optional build macro IMM_GEN_CSR_EN enables fmt Z decode of CSR-immediate instructions.
module imm_gen_pipe
  import imm_gen_pkg::*;
#(
  parameter int unsigned XLEN = 32,
  parameter int unsigned PC_W = XLEN
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            flush,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [31:0]     in_instr,
  input  logic [PC_W-1:0] in_pc,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] out_imm,
  output logic [2:0]      out_fmt,
  output logic            out_illegal,
  output logic [PC_W-1:0] out_target
);

  localparam int unsigned W = XLEN + PC_W + 4;
  localparam logic Rv64 = (XLEN == 64);

  dec_t            dec;
  logic [XLEN-1:0] imm;
  logic [PC_W-1:0] target;
  logic [W-1:0]    in_data;
  logic [W-1:0]    out_data;
  logic            unused_dec;

  always_comb begin
    dec    = decode_imm(in_instr, Rv64);
    imm    = dec.imm[XLEN-1:0];
    // Illegal and R-type carry imm 0, so target falls back to pc
    target = in_pc + dec.imm[PC_W-1:0];
  end

  assign unused_dec = ^dec.imm;
  assign in_data    = {imm, target, dec.fmt, dec.illegal};

  imm_skid_buf #(
    .W(W)
  ) u_skid (
    .clk      (clk),
    .rst_n    (rst_n),
    .flush    (flush),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_data  (in_data),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_data (out_data)
  );

  assign {out_imm, out_target, out_fmt, out_illegal} = out_data;

endmodule

// File: tb/tb_imm_gen_pipe.sv
// Bench for imm_gen_pipe: queue-level reference model plus directed literal checks.
module tb_imm_gen_pipe;

  localparam int unsigned XLEN = 32;
  localparam int unsigned PC_W = 32;

  localparam logic [2:0] F_NONE = 3'd0;
  localparam logic [2:0] F_R    = 3'd1;
  localparam logic [2:0] F_I    = 3'd2;
  localparam logic [2:0] F_S    = 3'd3;
  localparam logic [2:0] F_B    = 3'd4;
  localparam logic [2:0] F_U    = 3'd5;
  localparam logic [2:0] F_J    = 3'd6;
  localparam logic [2:0] F_Z    = 3'd7;

  logic            clk = 1'b0;
  logic            rst_n, flush, in_valid, out_ready;
  logic            in_ready, out_valid, out_illegal;
  logic [31:0]     in_instr;
  logic [PC_W-1:0] in_pc, out_target;
  logic [XLEN-1:0] out_imm;
  logic [2:0]      out_fmt;

  always #5 clk = ~clk;

  imm_gen_pipe #(
    .XLEN(XLEN),
    .PC_W(PC_W)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .flush      (flush),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_instr   (in_instr),
    .in_pc      (in_pc),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_imm    (out_imm),
    .out_fmt    (out_fmt),
    .out_illegal(out_illegal),
    .out_target (out_target)
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference decode built from arithmetic shifts/masks on the sign-extended word.
  function automatic void ref_decode(input logic [31:0] ins, input bit rv64,
                                     output logic [63:0] imm, output logic [2:0] fmt,
                                     output logic ill);
    longint s, r;
    s   = longint'($signed(ins));
    r   = 0;
    fmt = F_NONE;
    ill = 1'b0;
    if (ins[1:0] != 2'b11) begin
      ill = 1'b1;
    end else begin
      case (ins[6:0])
        7'h03, 7'h13, 7'h67: begin fmt = F_I; r = s >>> 20; end
        7'h23: begin fmt = F_S; r = ((s >>> 25) << 5) | ((s >> 7) & 31); end
        7'h63: begin
          fmt = F_B;
          r = ((s >>> 31) << 12) | (((s >> 7) & 1) << 11) | (((s >> 25) & 63) << 5)
            | (((s >> 8) & 15) << 1);
        end
        7'h37, 7'h17: begin fmt = F_U; r = (s >>> 12) << 12; end
        7'h6F: begin
          fmt = F_J;
          r = ((s >>> 31) << 20) | (((s >> 12) & 255) << 12) | (((s >> 20) & 1) << 11)
            | (((s >> 21) & 1023) << 1);
        end
        7'h33: fmt = F_R;
        7'h1B: if (rv64) begin fmt = F_I; r = s >>> 20; end else ill = 1'b1;
        7'h3B: if (rv64) fmt = F_R; else ill = 1'b1;
        7'h73: begin
`ifdef IMM_GEN_CSR_EN
          if (((s >> 14) & 1) != 0) begin fmt = F_Z; r = (s >> 15) & 31; end
          else begin fmt = F_I; r = s >>> 20; end
`else
          fmt = F_I;
          r = s >>> 20;
`endif
        end
        default: ill = 1'b1;
      endcase
    end
    imm = r;
  endfunction

  typedef struct {
    logic [XLEN-1:0] imm;
    logic [2:0]      fmt;
    logic            ill;
    logic [PC_W-1:0] tgt;
  } exp_t;

  exp_t q[$];
  logic exp_rdy = 1'b0;
  bit   started = 1'b0;

  // Model: the block is a FIFO of at most two beats; in_ready means fewer than two held.
  always @(posedge clk) begin
    exp_t        e;
    logic [63:0] im;
    logic [2:0]  f;
    logic        il;
    logic        acc;
    started = 1'b1;
    if (!rst_n) begin
      q.delete();
      exp_rdy = 1'b0;
    end else if (flush) begin
      q.delete();
      exp_rdy = 1'b1;
    end else begin
      acc = in_valid && exp_rdy;
      if (q.size() > 0 && out_ready) void'(q.pop_front());
      if (acc) begin
        ref_decode(in_instr, XLEN == 64, im, f, il);
        e.imm = im[XLEN-1:0];
        e.fmt = f;
        e.ill = il;
        e.tgt = in_pc + im[PC_W-1:0];
        q.push_back(e);
      end
      exp_rdy = (q.size() < 2);
    end
  end

  always @(negedge clk) begin
    if (started) begin
      chk("in_ready", 64'(in_ready), 64'(exp_rdy));
      chk("out_valid", 64'(out_valid), 64'(q.size() > 0));
      if (q.size() > 0) begin
        chk("out_imm", 64'(out_imm), 64'(q[0].imm));
        chk("out_fmt", 64'(out_fmt), 64'(q[0].fmt));
        chk("out_illegal", 64'(out_illegal), 64'(q[0].ill));
        chk("out_target", 64'(out_target), 64'(q[0].tgt));
      end
    end
  end

  typedef struct {
    logic [31:0] ins;
    logic [31:0] pc;
    logic [31:0] imm;
    logic [2:0]  fmt;
    logic        ill;
    logic [31:0] tgt;
  } vec_t;

  vec_t vecs[$];

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic drive(input logic v, input logic [31:0] ins, input logic [31:0] pc);
    in_valid = v;
    in_instr = ins;
    in_pc    = pc;
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog expired at %0t", $time);
    $fatal(1);
  end

  initial begin
    logic [63:0]        im;
    logic [2:0]         f;
    logic               il;
    imm_gen_pkg::dec_t  d;
    int                 seen;

    vecs.push_back('{32'hFFF00093, 32'h0,   32'hFFFFFFFF, F_I,    1'b0, 32'hFFFFFFFF});
    vecs.push_back('{32'hFE000EE3, 32'h100, 32'hFFFFFFFC, F_B,    1'b0, 32'h000000FC});
    vecs.push_back('{32'h123452B7, 32'h0,   32'h12345000, F_U,    1'b0, 32'h12345000});
    vecs.push_back('{32'h001000EF, 32'h40,  32'h00000800, F_J,    1'b0, 32'h00000840});
    vecs.push_back('{32'hFE112E23, 32'h20,  32'hFFFFFFFC, F_S,    1'b0, 32'h0000001C});
    vecs.push_back('{32'h002081B3, 32'h8,   32'h0,        F_R,    1'b0, 32'h8});
    vecs.push_back('{32'h00001017, 32'h10,  32'h00001000, F_U,    1'b0, 32'h00001010});
    vecs.push_back('{32'h00000000, 32'h200, 32'h0,        F_NONE, 1'b1, 32'h200});
    vecs.push_back('{32'h0000001B, 32'h300, 32'h0,        F_NONE, 1'b1, 32'h300});
    vecs.push_back('{32'h00000010, 32'h4,   32'h0,        F_NONE, 1'b1, 32'h4});
`ifdef IMM_GEN_CSR_EN
    vecs.push_back('{32'h3400D073, 32'h10,  32'h1,        F_Z,    1'b0, 32'h11});
`else
    vecs.push_back('{32'h3400D073, 32'h10,  32'h340,      F_I,    1'b0, 32'h350});
`endif

    // Pin the reference model and the package decoder to the hand-computed table
    foreach (vecs[i]) begin
      ref_decode(vecs[i].ins, 1'b0, im, f, il);
      chk("model_imm", im, {{32{vecs[i].imm[31]}}, vecs[i].imm});
      chk("model_fmt", 64'(f), 64'(vecs[i].fmt));
      chk("model_ill", 64'(il), 64'(vecs[i].ill));
      d = imm_gen_pkg::decode_imm(vecs[i].ins, 1'b0);
      chk("pkg_imm", d.imm, {{32{vecs[i].imm[31]}}, vecs[i].imm});
      chk("pkg_fmt", 64'(d.fmt), 64'(vecs[i].fmt));
    end
    ref_decode(32'h0000001B, 1'b1, im, f, il);
    chk("model_rv64_fmt", 64'(f), 64'(F_I));
    chk("model_rv64_ill", 64'(il), 64'd0);
    d = imm_gen_pkg::decode_imm(32'h0000001B, 1'b1);
    chk("pkg_rv64_fmt", 64'(d.fmt), 64'(F_I));
    d = imm_gen_pkg::decode_imm(32'h123452B7, 1'b1);
    chk("pkg_rv64_lui", d.imm, 64'h0000000012345000);

    // Reset
    rst_n = 1'b0; flush = 1'b0; out_ready = 1'b1;
    drive(1'b0, 32'h0, 32'h0);
    step();
    step();
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_in_ready", 64'(in_ready), 64'd0);
    chk("rst_out_imm", 64'(out_imm), 64'd0);
    chk("rst_out_fmt", 64'(out_fmt), 64'(F_NONE));
    chk("rst_out_illegal", 64'(out_illegal), 64'd0);
    chk("rst_out_target", 64'(out_target), 64'd0);
    rst_n = 1'b1;
    step();
    chk("rel_in_ready", 64'(in_ready), 64'd1);
    chk("rel_out_valid", 64'(out_valid), 64'd0);

    // Streaming, one beat per cycle with latency 1
    foreach (vecs[i]) begin
      drive(1'b1, vecs[i].ins, vecs[i].pc);
      step();
      chk("lit_valid", 64'(out_valid), 64'd1);
      chk("lit_imm", 64'(out_imm), 64'(vecs[i].imm));
      chk("lit_fmt", 64'(out_fmt), 64'(vecs[i].fmt));
      chk("lit_illegal", 64'(out_illegal), 64'(vecs[i].ill));
      chk("lit_target", 64'(out_target), 64'(vecs[i].tgt));
    end
    drive(1'b0, 32'h0, 32'h0);
    step();
    chk("drained", 64'(out_valid), 64'd0);

    // Backpressure: three beats offered while the sink stalls
    out_ready = 1'b0;
    drive(1'b1, vecs[0].ins, vecs[0].pc);
    step();
    drive(1'b1, vecs[1].ins, vecs[1].pc);
    step();
    chk("bp_ready_full", 64'(in_ready), 64'd0);
    drive(1'b1, vecs[2].ins, vecs[2].pc);
    step();
    chk("bp_hold_imm", 64'(out_imm), 64'hFFFFFFFF);
    chk("bp_still_full", 64'(in_ready), 64'd0);
    out_ready = 1'b1;
    step();
    chk("bp_out2_valid", 64'(out_valid), 64'd1);
    chk("bp_out2_imm", 64'(out_imm), 64'hFFFFFFFC);
    step();
    chk("bp_out3_valid", 64'(out_valid), 64'd1);
    chk("bp_out3_imm", 64'(out_imm), 64'h12345000);
    drive(1'b0, 32'h0, 32'h0);
    step();
    chk("bp_empty", 64'(out_valid), 64'd0);

    // Flush with output and skid both full, plus a beat offered in the flush cycle
    out_ready = 1'b0;
    drive(1'b1, vecs[3].ins, vecs[3].pc);
    step();
    drive(1'b1, vecs[4].ins, vecs[4].pc);
    step();
    drive(1'b1, vecs[5].ins, vecs[5].pc);
    flush = 1'b1;
    step();
    flush = 1'b0;
    chk("fl_out_valid", 64'(out_valid), 64'd0);
    chk("fl_in_ready", 64'(in_ready), 64'd1);
    drive(1'b0, 32'h0, 32'h0);
    out_ready = 1'b1;
    seen = 0;
    repeat (3) begin
      step();
      if (out_valid) seen++;
    end
    chk("fl_no_beats", 64'(seen), 64'd0);

    // Flush while ready: the offered beat is discarded
    drive(1'b1, vecs[6].ins, vecs[6].pc);
    flush = 1'b1;
    step();
    flush = 1'b0;
    drive(1'b0, 32'h0, 32'h0);
    chk("fl2_out_valid", 64'(out_valid), 64'd0);
    step();
    chk("fl2_still_empty", 64'(out_valid), 64'd0);

    // Reset takes priority over flush
    drive(1'b1, vecs[0].ins, vecs[0].pc);
    rst_n = 1'b0;
    flush = 1'b1;
    step();
    chk("rf_in_ready", 64'(in_ready), 64'd0);
    chk("rf_out_valid", 64'(out_valid), 64'd0);
    rst_n = 1'b1;
    flush = 1'b0;
    drive(1'b0, 32'h0, 32'h0);
    step();
    chk("rf_rel_ready", 64'(in_ready), 64'd1);
    step();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
